// File: rtl/fp_pkg.sv
// Shared widths, constants, FSM states and operand class flags for the FP adder front end.
// Pure declarations: no latency or backpressure of its own.
package fp_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 32;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam int BIAS = 127;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    OP,
    DONE
  } alignStateE;

  typedef struct packed {
    logic isNaN;
    logic isInf;
    logic isZero;
  } fpClassT;

  function automatic int unbiasedExp(input logic [EXP_W-1:0] e);
    return int'(e) - BIAS;
  endfunction
endpackage

// File: rtl/fp_align_unpack_if.sv
// Operand/result bundle between the producer, the align stage and the normalize stage.
// slave: the align stage; master: whoever drives operands and consumes results.
interface fp_align_unpack_if;
  import fp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       A;
  logic [31:0]       B;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       A_q;
  logic [31:0]       B_q;
  logic              signA;
  logic              signB;
  logic              ANaN;
  logic              BNaN;
  logic              Ainf;
  logic              Binf;
  logic              Azero;
  logic              Bzero;
  logic              alignedSign;
  logic [MANT_W-1:0] alignedResult;
  logic              carryOut;
  logic [EXP_W-1:0]  exponentOut;

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, A_q, B_q, signA, signB,
           ANaN, BNaN, Ainf, Binf, Azero, Bzero,
           alignedSign, alignedResult, carryOut, exponentOut
  );

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, A_q, B_q, signA, signB,
           ANaN, BNaN, Ainf, Binf, Azero, Bzero,
           alignedSign, alignedResult, carryOut, exponentOut
  );
endinterface

// File: rtl/fp_classify.sv
// Combinational unpack/classify of one IEEE-754 single; no latency, no backpressure.
// FP_FLUSH_SUBNORMAL_EN: subnormals are reported as zero with a zero mantissa.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0]       op,
  output logic              sign,
  output logic [EXP_W-1:0]  effExp,
  output logic [MANT_W-1:0] mant,
  output fpClassT           cls
);
  logic [EXP_W-1:0]  expField;
  logic [FRAC_W-1:0] frac;
  logic              expIsZero;

  always_comb begin
    expField  = op[30:23];
    frac      = op[22:0];
    expIsZero = (expField == '0);
    sign      = op[31];
    effExp    = expIsZero ? 8'd1 : expField;

    cls.isNaN = (expField == EXP_MAX) && (frac != '0);
    cls.isInf = (expField == EXP_MAX) && (frac == '0);
`ifdef FP_FLUSH_SUBNORMAL_EN
    cls.isZero = expIsZero;
    mant       = expIsZero ? '0 : {1'b1, frac, 8'b0};
`else
    cls.isZero = expIsZero && (frac == '0);
    mant       = {~expIsZero, frac, 8'b0};
`endif
  end
endmodule

// File: rtl/fp_align_unpack.sv
// FP adder front end: classify, magnitude-order, iteratively align and add/subtract.
// Latency ceil(d/SHIFT_STEP)+1 edges after accept; one in flight; result held until out_ready.
module fp_align_unpack
  import fp_pkg::*;
#(
  parameter int SHIFT_STEP = 4,
  parameter int MAX_SHIFT  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_align_unpack_if.slave  bus
);
  localparam logic [5:0]       STEP = 6'(SHIFT_STEP);
  localparam logic [EXP_W-1:0] MAXD = EXP_W'(MAX_SHIFT);

  logic              signAc, signBc;
  logic [EXP_W-1:0]  expAc, expBc;
  logic [MANT_W-1:0] mantAc, mantBc;
  fpClassT           clsA, clsB;

  fp_classify uClassA (.op(bus.A), .sign(signAc), .effExp(expAc), .mant(mantAc), .cls(clsA));
  fp_classify uClassB (.op(bus.B), .sign(signBc), .effExp(expBc), .mant(mantBc), .cls(clsB));

  alignStateE        state;
  logic [5:0]        remaining;
  logic [MANT_W-1:0] mantL, mantS;
  logic [EXP_W-1:0]  expL;
  logic              signL, effSub, special;

  logic              swapAB, specialIn;
  logic [EXP_W-1:0]  expDiff;
  logic [5:0]        distIn, stepNow;
  logic [63:0]       shiftWide;
  logic [MANT_W:0]   sum33;

  always_comb begin
    // B only wins on strictly greater magnitude, so equal magnitudes keep A as larger.
    swapAB    = {expBc, mantBc} > {expAc, mantAc};
    expDiff   = swapAB ? (expBc - expAc) : (expAc - expBc);
    distIn    = (expDiff > MAXD) ? MAXD[5:0] : expDiff[5:0];
    specialIn = (|clsA) | (|clsB);
    stepNow   = (remaining > STEP) ? STEP : remaining;
    // Lower half of the wide shift holds the bits falling off the end.
    shiftWide = {mantS, 32'b0} >> stepNow;
    sum33     = effSub ? ({1'b0, mantL} - {1'b0, mantS}) : ({1'b0, mantL} + {1'b0, mantS});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      remaining         <= '0;
      mantL             <= '0;
      mantS             <= '0;
      expL              <= '0;
      signL             <= 1'b0;
      effSub            <= 1'b0;
      special           <= 1'b0;
      bus.in_ready      <= 1'b1;
      bus.out_valid     <= 1'b0;
      bus.A_q           <= '0;
      bus.B_q           <= '0;
      bus.signA         <= 1'b0;
      bus.signB         <= 1'b0;
      bus.ANaN          <= 1'b0;
      bus.BNaN          <= 1'b0;
      bus.Ainf          <= 1'b0;
      bus.Binf          <= 1'b0;
      bus.Azero         <= 1'b0;
      bus.Bzero         <= 1'b0;
      bus.alignedSign   <= 1'b0;
      bus.alignedResult <= '0;
      bus.carryOut      <= 1'b0;
      bus.exponentOut   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            bus.A_q      <= bus.A;
            bus.B_q      <= bus.B;
            bus.signA    <= signAc;
            bus.signB    <= signBc;
            bus.ANaN     <= clsA.isNaN;
            bus.BNaN     <= clsB.isNaN;
            bus.Ainf     <= clsA.isInf;
            bus.Binf     <= clsB.isInf;
            bus.Azero    <= clsA.isZero;
            bus.Bzero    <= clsB.isZero;
            bus.in_ready <= 1'b0;
            mantL        <= swapAB ? mantBc : mantAc;
            mantS        <= swapAB ? mantAc : mantBc;
            expL         <= swapAB ? expBc : expAc;
            signL        <= swapAB ? signBc : signAc;
            effSub       <= signAc ^ signBc;
            special      <= specialIn;
            remaining    <= distIn;
            state        <= (specialIn || distIn == '0) ? OP : SHIFT;
          end
        end
        SHIFT: begin
          mantS     <= shiftWide[63:32] | {31'b0, |shiftWide[31:0]};
          remaining <= remaining - stepNow;
          if (remaining == stepNow) state <= OP;
        end
        OP: begin
          if (special || sum33 == '0) begin
            bus.alignedSign   <= 1'b0;
            bus.exponentOut   <= '0;
            bus.alignedResult <= '0;
            bus.carryOut      <= 1'b0;
          end else begin
            bus.alignedSign   <= signL;
            bus.exponentOut   <= expL;
            bus.alignedResult <= sum33[MANT_W-1:0];
            bus.carryOut      <= sum33[MANT_W];
          end
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_align_unpack.sv
// Randomized self-checking bench for fp_align_unpack against a whole-number reference model.
// Honours FP_FLUSH_SUBNORMAL_EN the same way as the design build.
module tb_fp_align_unpack;
  localparam int STEP = 4;
  localparam int MAXS = 32;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  fp_align_unpack_if bus ();

  fp_align_unpack #(.SHIFT_STEP(STEP), .MAX_SHIFT(MAXS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit [31:0] res;
    bit        carry;
    bit [7:0]  expo;
    bit        sgn;
    bit [5:0]  flags;
    int        n;
  } expT;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic void unpack(input bit [31:0] x, output longint effE, output longint m,
                                 output bit nan, output bit inf, output bit zero);
    int e;
    longint f;
    e    = int'(x[30:23]);
    f    = longint'(x[22:0]);
    nan  = (e == 255) && (f != 0);
    inf  = (e == 255) && (f == 0);
    zero = (e == 0) && (f == 0);
    effE = (e == 0) ? 1 : e;
    m    = (e == 0) ? f * 256 : (f + 64'd8388608) * 256;
`ifdef FP_FLUSH_SUBNORMAL_EN
    if (e == 0) begin
      zero = 1'b1;
      m    = 0;
    end
`endif
  endfunction

  function automatic expT refModel(input bit [31:0] a, input bit [31:0] b);
    expT    r;
    longint eA, eB, mA, mB, eL, eS, mL, mS, d, sh, val;
    bit     nA, nB, iA, iB, zA, zB, sL, sS, special;
    unpack(a, eA, mA, nA, iA, zA);
    unpack(b, eB, mB, nB, iB, zB);
    r.flags = {nA, nB, iA, iB, zA, zB};
    special = nA | nB | iA | iB | zA | zB;
    if (eB * 64'h1_0000_0000 + mB > eA * 64'h1_0000_0000 + mA) begin
      eL = eB; mL = mB; sL = b[31]; eS = eA; mS = mA; sS = a[31];
    end else begin
      eL = eA; mL = mA; sL = a[31]; eS = eB; mS = mB; sS = b[31];
    end
    d = eL - eS;
    if (d > MAXS) d = MAXS;
    r.n = special ? 0 : int'((d + STEP - 1) / STEP);
    sh = mS >> d;
    if (mS - (sh << d) != 0) sh = sh | 1;
    val = (sL == sS) ? mL + sh : mL - sh;
    if (special || val == 0) begin
      r.res = 0; r.carry = 0; r.expo = 0; r.sgn = 0;
    end else begin
      r.res   = val[31:0];
      r.carry = val[32];
      r.expo  = eL[7:0];
      r.sgn   = sL;
    end
    return r;
  endfunction

  task automatic checkOutputs(input string tag, input bit [31:0] a, input bit [31:0] b, input expT e);
    checkEq({tag, ".res"},   bus.alignedResult, e.res);
    checkEq({tag, ".carry"}, bus.carryOut, e.carry);
    checkEq({tag, ".exp"},   bus.exponentOut, e.expo);
    checkEq({tag, ".sign"},  bus.alignedSign, e.sgn);
    checkEq({tag, ".flags"}, {bus.ANaN, bus.BNaN, bus.Ainf, bus.Binf, bus.Azero, bus.Bzero}, e.flags);
    checkEq({tag, ".Aq"},    bus.A_q, a);
    checkEq({tag, ".Bq"},    bus.B_q, b);
    checkEq({tag, ".signs"}, {bus.signA, bus.signB}, {a[31], b[31]});
  endtask

  task automatic runTxn(input string tag, input bit [31:0] a, input bit [31:0] b, input int holdCyc);
    expT e;
    int  edges;
    e = refModel(a, b);
    @(negedge clk);
    checkEq({tag, ".idleReady"}, bus.in_ready, 1'b1);
    bus.in_valid  = 1'b1;
    bus.A         = a;
    bus.B         = b;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    edges = 0;
    while (!bus.out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkEq({tag, ".latency"}, edges, e.n + 1);
    checkOutputs(tag, a, b, e);
    for (int i = 0; i < holdCyc; i++) begin
      @(posedge clk);
      #1;
      checkEq({tag, ".holdVld"}, {bus.out_valid, bus.in_ready}, 2'b10);
      checkOutputs({tag, ".hold"}, a, b, e);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkEq({tag, ".release"}, {bus.out_valid, bus.in_ready}, 2'b01);
  endtask

  function automatic bit [31:0] mkOp(input int kind, input int e);
    bit [22:0] f;
    bit        s;
    int        ec;
    f  = 23'($urandom);
    s  = 1'($urandom);
    ec = (e < 1) ? 1 : ((e > 254) ? 254 : e);
    case (kind)
      0:       return {s, 8'hFF, f | 23'd1};
      1:       return {s, 8'hFF, 23'd0};
      2:       return {s, 8'h00, 23'd0};
      3:       return {s, 8'h00, f | 23'd1};
      default: return {s, 8'(ec), f};
    endcase
  endfunction

  initial begin
    bit [31:0] a, b;
    int        eA, kA, kB;
    tests = 0;
    fails = 0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    checkEq("reset.hs", {bus.in_ready, bus.out_valid}, 2'b10);
    checkEq("reset.data", {bus.alignedResult, bus.carryOut, bus.exponentOut, bus.A_q[22:0]}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runTxn("t1", 32'h3F800000, 32'h3F800000, 0);
    runTxn("t2", 32'h3F800000, 32'h30800000, 0);
    runTxn("t3", 32'h3F800000, 32'hBF800000, 0);
    runTxn("t4", 32'h7FC00000, 32'h3F800000, 0);
    runTxn("t5", 32'h3F800000, 32'h3F800000, 3);
    runTxn("sub", 32'h00400000, 32'h00200001, 1);
    runTxn("far", 32'h4F000000, 32'hB0800001, 0);

    // Reset in the third SHIFT cycle of the d=30 case.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = 32'h3F800000;
    bus.B        = 32'h30800000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkEq("t6.hs", {bus.in_ready, bus.out_valid}, 2'b10);
    checkEq("t6.res", {bus.alignedResult, bus.exponentOut, bus.carryOut, bus.alignedSign}, 64'd0);
    checkEq("t6.regs", {bus.A_q, bus.B_q}, 64'd0);
    checkEq("t6.flags", {bus.ANaN, bus.BNaN, bus.Ainf, bus.Binf, bus.Azero, bus.Bzero, bus.signA, bus.signB}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    runTxn("t6.after", 32'h3F800000, 32'h3F800000, 0);

    for (int i = 0; i < 150; i++) begin
      kA = int'($urandom_range(0, 11));
      kB = int'($urandom_range(0, 12));
      eA = int'($urandom_range(1, 254));
      a  = mkOp(kA, eA);
      if (kB == 12) b = a ^ 32'h80000000;
      else          b = mkOp(kB, eA + int'($urandom_range(0, 80)) - 40);
      runTxn($sformatf("rnd%0d", i), a, b, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_align_unpack.md
Name: fp_align_unpack

Overview:
- Front end of the FP adder; the producer side of the interface the normalize stage consumes.
- Accepts two IEEE-754 single operands via valid/ready and classifies them (NaN/inf/zero/subnormal).
- Orders operands by magnitude and right-shifts the smaller mantissa iteratively, collecting sticky.
- Performs the effective add/subtract, then holds aligned result, carry, exponent, sign and class flags until the consumer accepts.

Parameters:
SHIFT_STEP, 4, max right-shift bits per SHIFT cycle (1..32).
MAX_SHIFT, 32, cap on alignment distance; larger differences leave only sticky.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept (high only in IDLE)
A  in  32  operand A, IEEE-754 single
B  in  32  operand B, IEEE-754 single
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
A_q, B_q  out  32 each  registered raw operands (NaN/inf/zero pass-through)
signA, signB  out  1 each  operand signs
ANaN, BNaN, Ainf, Binf, Azero, Bzero  out  1 each  class flags
alignedSign  out  1  sign of result
alignedResult  out  32  magnitude; hidden bit at [31], fraction [30:8], guard/sticky [7:0]
carryOut  out  1  bit 32 of effective addition
exponentOut  out  8  larger effective exponent

Behaviour:
- Reset (async, rst_n low): state IDLE, in_ready=1, out_valid=0, all other outputs 0. Reset mid-operation discards the transaction.
- Unpack: exp field 0 → effective exponent 1, hidden bit 0; otherwise hidden bit 1. Mantissa register = {hidden, frac[22:0], 8'b0}.
- Classify: NaN = exp FF, frac≠0. inf = exp FF, frac=0. zero = exp 0, frac=0.
- States: IDLE, SHIFT, OP, DONE.
- IDLE: on in_valid && in_ready, register operands, flags and signs.
  - Order by {effective exponent, mantissa}; ties keep A as larger.
  - d = min(expL−expS, MAX_SHIFT).
  - Next state: OP if any special flag is set or d=0; else SHIFT.
- SHIFT: each cycle shift the smaller mantissa right by min(SHIFT_STEP, remaining). OR the shifted-out bits into bit 0 (sticky). Decrement remaining; go to OP at 0.
- OP: effective subtract when signs differ, else add. 33-bit result: {carryOut, alignedResult}.
  - Subtract is L−S, so never negative. alignedSign = sign of larger.
  - Exact-zero difference: alignedSign=0, exponentOut=0, alignedResult=0, carryOut=0.
  - Special cases: arithmetic outputs are 0; flags, A_q and B_q carry the information.
  - Next state: DONE.
- DONE: out_valid=1, all outputs stable. On out_ready go to IDLE (out_valid=0 next cycle). No new input is accepted in the same cycle.
- Latency: out_valid rises N+1 clock edges after the accepting edge, N = ceil(d/SHIFT_STEP) (0 for specials).
- Throughput: one transaction in flight.
- Backpressure: out_ready may be held low indefinitely with no output change.
- in_valid while busy: ignored; the producer must hold.

Optional Feature:
FP_FLUSH_SUBNORMAL_EN
- Defined: any subnormal operand (exp 0, frac≠0) is treated as zero; the matching Azero/Bzero flag asserts and its mantissa is forced to 0.
- Undefined: gradual subnormals as described above.

Decomposition:
- Package fp_pkg: field widths (EXP_W=8, FRAC_W=23, MANT_W=32), constants EXP_MAX=8'hFF and BIAS=127, state enum, and a packed struct for the operand class flags.
- Sub-module fp_classify: combinational, one instance per operand. Outputs sign, effective exponent, mantissa and flags; contains the FP_FLUSH_SUBNORMAL_EN logic.

Test Plan:
1. A=3F800000, B=3F800000 → out_valid 1 edge after accept; carryOut=1, alignedResult=00000000, exponentOut=7F, alignedSign=0.
2. A=3F800000, B=30800000 (d=30, SHIFT_STEP=4) → 8 SHIFT cycles, out_valid 9 edges after accept; alignedResult=80000002, carryOut=0, exponentOut=7F.
3. A=3F800000, B=BF800000 → alignedResult=0, carryOut=0, alignedSign=0, exponentOut=00.
4. A=7FC00000, B=3F800000 → ANaN=1, no SHIFT, out_valid 1 edge after accept, A_q=7FC00000.
5. Test 1 with out_ready low 3 cycles → outputs stable and in_ready=0 throughout; after the handshake, in_ready=1 the next cycle.
6. Test 2 with rst_n pulsed low in the 3rd SHIFT cycle → all outputs 0 immediately and in_ready=1. A fresh 1.0+1.0 afterwards matches test 1.
